tbird_seq: RTL and testbench

Parametrised Thunderbird tail-light sequencer, the successor to the fixed 3-lamp turn-signal FSM. It supports N lamps per side, a programmable step period via a clock-enable prescaler, a brake override, and a repeating hazard flash. It sits between the driver-control input synchroniser and the lamp driver outputs in the tail-light controller.

---
 rtl/tbird_pkg.sv | 17 +
 rtl/tbird_tick_div.sv | 35 +++
 rtl/tbird_seq.sv | 161 ++++++++++++++++
 tb/tb_tbird_seq.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tbird_pkg.sv
// Shared types and parameter bounds for the tail-light sequencer.
package tbird_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SWEEP_L = 3'd1,
        SWEEP_R = 3'd2,
        BLANK   = 3'd3,
        HAZ_ON  = 3'd4,
        HAZ_OFF = 3'd5
    } t_tbird_seq_state;

    localparam int N_LAMPS_MIN  = 1;
    localparam int N_LAMPS_MAX  = 16;
    localparam int TICK_DIV_MIN = 1;

endpackage

// File: rtl/tbird_tick_div.sv
// Animation-step prescaler: tick pulses once every TICK_DIV clocks; clr restarts the count.
module tbird_tick_div
    import tbird_pkg::*;
#(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst_b,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [CW-1:0] count_r;

    // Wrapping cycle counter, restarted when the sequencer leaves IDLE
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            count_r <= CNT_ZERO;
        end else if (clr) begin
            count_r <= CNT_ZERO;
        end else if (count_r == CNT_LAST) begin
            count_r <= CNT_ZERO;
        end else begin
            count_r <= count_r + CNT_ONE;
        end
    end

    assign tick = (count_r == CNT_LAST);

endmodule

// File: rtl/tbird_seq.sv
// Thunderbird tail-light sequencer: N-lamp turn sweeps, hazard flash and brake override.
module tbird_seq
    import tbird_pkg::*;
#(
    parameter int N_LAMPS  = 3,
    parameter int TICK_DIV = 4
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic               left,
    input  logic               right,
    input  logic               haz,
    input  logic               brake,
    output logic [N_LAMPS-1:0] l_lights,
    output logic [N_LAMPS-1:0] r_lights,
    output logic               busy
);

    localparam int SW = $clog2(N_LAMPS + 1);
    localparam logic [SW-1:0]      STEP_ONE  = SW'(1);
    localparam logic [SW-1:0]      STEP_LAST = SW'(N_LAMPS);
    localparam logic [N_LAMPS-1:0] ALL_ON    = {N_LAMPS{1'b1}};
    localparam logic [N_LAMPS-1:0] ALL_OFF   = {N_LAMPS{1'b0}};

    if ((N_LAMPS < N_LAMPS_MIN) || (N_LAMPS > N_LAMPS_MAX) || (TICK_DIV < TICK_DIV_MIN)) begin : g_param_check
        $error("tbird_seq: illegal parameters N_LAMPS=%0d TICK_DIV=%0d", N_LAMPS, TICK_DIV);
    end

    t_tbird_seq_state   state_r;
    t_tbird_seq_state   state_nxt_s;
    logic [SW-1:0]      step_r;
    logic [SW-1:0]      step_nxt_s;
    logic               tick_s;
    logic               clr_s;
    logic [N_LAMPS-1:0] therm_s;
    logic [N_LAMPS-1:0] l_dec_s;
    logic [N_LAMPS-1:0] r_dec_s;

    tbird_tick_div #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_div (
        .clk   (clk),
        .rst_b (rst_b),
        .clr   (clr_s),
        .tick  (tick_s)
    );

    // Next-state and step logic; IDLE reacts every edge, all other states only on tick
    always_comb begin
        state_nxt_s = state_r;
        step_nxt_s  = step_r;
        case (state_r)
            IDLE: begin
                if (haz || (left && right)) begin
                    state_nxt_s = HAZ_ON;
                end else if (left) begin
                    state_nxt_s = SWEEP_L;
                    step_nxt_s  = STEP_ONE;
                end else if (right) begin
                    state_nxt_s = SWEEP_R;
                    step_nxt_s  = STEP_ONE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SWEEP_L, SWEEP_R: begin
                if (!tick_s) begin
                    state_nxt_s = state_r;
                end else if (haz) begin
                    state_nxt_s = HAZ_ON;
                end else if (step_r < STEP_LAST) begin
                    step_nxt_s = step_r + STEP_ONE;
                end else begin
                    state_nxt_s = BLANK;
                end
            end
            BLANK: begin
                if (tick_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = BLANK;
                end
            end
            HAZ_ON: begin
                if (tick_s) begin
                    state_nxt_s = HAZ_OFF;
                end else begin
                    state_nxt_s = HAZ_ON;
                end
            end
            HAZ_OFF: begin
                if (!tick_s) begin
                    state_nxt_s = HAZ_OFF;
                end else if (haz || (left && right)) begin
                    state_nxt_s = HAZ_ON;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                step_nxt_s  = STEP_ONE;
            end
        endcase
    end

    assign clr_s = (state_r == IDLE) && (state_nxt_s != IDLE);

    // FSM and step counter registers
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_r <= IDLE;
            step_r  <= STEP_ONE;
        end else begin
            state_r <= state_nxt_s;
            step_r  <= step_nxt_s;
        end
    end

    // Lamp decode with brake override; the sweeping side is never forced
    always_comb begin
        l_dec_s = ALL_OFF;
        r_dec_s = ALL_OFF;
        therm_s = ALL_OFF;
        for (int i = 0; i < N_LAMPS; i++) begin
            therm_s[i] = (i < int'(step_r));
        end
        case (state_r)
            SWEEP_L: begin
                l_dec_s = therm_s;
                r_dec_s = brake ? ALL_ON : ALL_OFF;
            end
            SWEEP_R: begin
                l_dec_s = brake ? ALL_ON : ALL_OFF;
                r_dec_s = therm_s;
            end
            HAZ_ON: begin
                l_dec_s = ALL_ON;
                r_dec_s = ALL_ON;
            end
            HAZ_OFF: begin
                l_dec_s = ALL_OFF;
                r_dec_s = ALL_OFF;
            end
            IDLE, BLANK: begin
                l_dec_s = brake ? ALL_ON : ALL_OFF;
                r_dec_s = brake ? ALL_ON : ALL_OFF;
            end
            default: begin
                l_dec_s = ALL_OFF;
                r_dec_s = ALL_OFF;
            end
        endcase
    end

    // Lamps go dark the moment reset asserts, even if brake is held
    assign l_lights = rst_b ? l_dec_s : ALL_OFF;
    assign r_lights = rst_b ? r_dec_s : ALL_OFF;
    assign busy     = rst_b && (state_r != IDLE);

endmodule

// File: tb/tb_tbird_seq.sv
// Bench for tbird_seq: two configurations checked every cycle against a time-based model.
module tb_tbird_seq;

    localparam int NA = 3, TA = 2;
    localparam int NB = 5, TB = 1;
    localparam int M_IDLE = 0, M_LEFT = 1, M_RIGHT = 2, M_HAZ = 3;

    logic clk = 1'b0, rst_b = 1'b0;
    logic left = 1'b0, right = 1'b0, haz = 1'b0, brake = 1'b0;
    logic [NA-1:0] la, ra;
    logic [NB-1:0] lb, rb;
    logic busy_a, busy_b;

    int vectors = 0, errors = 0;
    bit chk_en = 1'b0;
    int mode_m [2];
    int t_m [2];
    logic [63:0] nx_a, nx_b;

    logic [2:0] seq_a [8] = '{3'b001, 3'b001, 3'b011, 3'b011, 3'b111, 3'b111, 3'b000, 3'b000};
    logic [4:0] seq_b [7] = '{5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111, 5'b00000, 5'b00000};

    always #5 clk = ~clk;

    tbird_seq #(.N_LAMPS(NA), .TICK_DIV(TA)) dut_a (
        .clk(clk), .rst_b(rst_b), .left(left), .right(right), .haz(haz), .brake(brake),
        .l_lights(la), .r_lights(ra), .busy(busy_a));

    tbird_seq #(.N_LAMPS(NB), .TICK_DIV(TB)) dut_b (
        .clk(clk), .rst_b(rst_b), .left(left), .right(right), .haz(haz), .brake(brake),
        .l_lights(lb), .r_lights(rb), .busy(busy_b));

    // Model: activity kind plus cycles elapsed since it started; steps end every td cycles
    function automatic logic [63:0] adv(int m, int tt, int n, int td, logic l, logic r, logic h);
        int nm, nt, idx;
        bit bnd;
        nm = m;
        nt = tt + 1;
        idx = tt / td;
        bnd = (tt % td) == (td - 1);
        if (m == M_IDLE) begin
            nt = 0;
            if (h || (l && r)) nm = M_HAZ;
            else if (l) nm = M_LEFT;
            else if (r) nm = M_RIGHT;
        end else if (m == M_HAZ) begin
            if (bnd && (idx % 2 == 1)) begin
                nt = 0;
                if (!(h || (l && r))) nm = M_IDLE;
            end
        end else if (bnd) begin
            if (idx < n && h) begin
                nm = M_HAZ;
                nt = 0;
            end else if (idx == n) begin
                nm = M_IDLE;
            end
        end
        return {32'(nm), 32'(nt)};
    endfunction

    function automatic logic [32:0] exp_out(int m, int tt, int n, int td, logic b, logic rb_n);
        logic [15:0] all, th, el, er, bk;
        int idx;
        all = 16'((32'd1 << n) - 1);
        bk  = b ? all : 16'd0;
        idx = tt / td;
        el = bk;
        er = bk;
        if (m == M_LEFT || m == M_RIGHT) begin
            if (idx < n) begin
                th = 16'((32'd1 << (idx + 1)) - 1);
                if (m == M_LEFT) el = th;
                else er = th;
            end
        end else if (m == M_HAZ) begin
            el = ((idx % 2) == 0) ? all : 16'd0;
            er = el;
        end
        if (!rb_n) return 33'd0;
        return {(m != M_IDLE), el, er};
    endfunction

    always_comb begin
        nx_a = adv(mode_m[0], t_m[0], NA, TA, left, right, haz);
        nx_b = adv(mode_m[1], t_m[1], NB, TB, left, right, haz);
    end

    // Model state update, with the same asynchronous reset as the design
    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            mode_m[0] <= M_IDLE; t_m[0] <= 0;
            mode_m[1] <= M_IDLE; t_m[1] <= 0;
        end else begin
            mode_m[0] <= int'(nx_a[63:32]); t_m[0] <= int'(nx_a[31:0]);
            mode_m[1] <= int'(nx_b[63:32]); t_m[1] <= int'(nx_b[31:0]);
        end
    end

    task automatic cmp(string nm, logic [32:0] e, logic [15:0] al, logic [15:0] ar, logic ab);
        vectors++;
        if ({ab, al, ar} !== e) begin
            errors++;
            $display("FAIL %s @%0t: got l=%h r=%h busy=%b, want l=%h r=%h busy=%b",
                     nm, $time, al, ar, ab, e[31:16], e[15:0], e[32]);
        end
    endtask

    task automatic lit(string nm, logic [15:0] act, logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h, want %h", nm, $time, act, exp);
        end
    endtask

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("model_a", exp_out(mode_m[0], t_m[0], NA, TA, brake, rst_b), 16'(la), 16'(ra), busy_a);
            cmp("model_b", exp_out(mode_m[1], t_m[1], NB, TB, brake, rst_b), 16'(lb), 16'(rb), busy_b);
        end
    end

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    task automatic settle();
        left = 1'b0; right = 1'b0; haz = 1'b0; brake = 1'b0;
        repeat (12) nxt();
    endtask

    initial begin
        #6;
        lit("reset_la", 16'(la), 16'd0);
        lit("reset_ra", 16'(ra), 16'd0);
        lit("reset_busy", 16'(busy_a), 16'd0);
        lit("reset_busy_b", 16'(busy_b), 16'd0);
        nxt();
        rst_b = 1'b1;
        chk_en = 1'b1;
        nxt();

        // single-cycle left pulse
        left = 1'b1; nxt(); left = 1'b0;
        for (int i = 0; i < 8; i++) begin
            lit("pulse_l", 16'(la), 16'(seq_a[i]));
            lit("pulse_r", 16'(ra), 16'd0);
            lit("pulse_busy", 16'(busy_a), 16'd1);
            nxt();
        end
        lit("pulse_idle", 16'(busy_a), 16'd0);
        settle();

        // hazard held, released in the middle of an ON phase
        haz = 1'b1; nxt();
        for (int i = 0; i < 14; i++) begin
            lit("haz_l", 16'(la), (i < 12 && (i / 2) % 2 == 0) ? 16'd7 : 16'd0);
            lit("haz_r", 16'(ra), (i < 12 && (i / 2) % 2 == 0) ? 16'd7 : 16'd0);
            lit("haz_busy", 16'(busy_a), (i < 12) ? 16'd1 : 16'd0);
            if (i == 9) haz = 1'b0;
            nxt();
        end
        settle();

        // right sweep preempted by hazard during step 2
        right = 1'b1; nxt();
        for (int i = 0; i < 6; i++) begin
            lit("pre_r", 16'(ra), (i < 2) ? 16'd1 : (i < 4) ? 16'd3 : 16'd7);
            lit("pre_l", 16'(la), (i < 4) ? 16'd0 : 16'd7);
            if (i == 2) haz = 1'b1;
            nxt();
        end
        settle();
        left = 1'b1; right = 1'b1; nxt();
        lit("lr_haz_l", 16'(la), 16'd7);
        lit("lr_haz_r", 16'(ra), 16'd7);
        settle();

        // brake during a left sweep, in IDLE, and in HAZ_OFF
        left = 1'b1; nxt(); left = 1'b0; nxt();
        brake = 1'b1; #1;
        lit("brk_sweep_r", 16'(ra), 16'd7);
        lit("brk_sweep_l", 16'(la), 16'd1);
        nxt();
        lit("brk_sweep_l2", 16'(la), 16'd3);
        settle();
        brake = 1'b1; #1;
        lit("brk_idle_l", 16'(la), 16'd7);
        lit("brk_idle_r", 16'(ra), 16'd7);
        settle();
        haz = 1'b1; nxt(); haz = 1'b0; nxt(); nxt();
        brake = 1'b1; #1;
        lit("brk_hoff_l", 16'(la), 16'd0);
        lit("brk_hoff_r", 16'(ra), 16'd0);
        lit("brk_hoff_busy", 16'(busy_a), 16'd1);
        settle();

        // asynchronous reset in SWEEP_R step 3
        right = 1'b1; nxt(); right = 1'b0;
        repeat (4) nxt();
        lit("rst_pre_r", 16'(ra), 16'd7);
        #2 rst_b = 1'b0;
        #1;
        lit("rst_async_r", 16'(ra), 16'd0);
        lit("rst_async_l", 16'(la), 16'd0);
        lit("rst_async_busy", 16'(busy_a), 16'd0);
        nxt();
        rst_b = 1'b1;
        nxt();
        right = 1'b1; nxt(); right = 1'b0;
        lit("rst_restart_r", 16'(ra), 16'd1);
        settle();

        // randomized traffic, with occasional resets
        for (int c = 0; c < 500; c++) begin
            left  = ($urandom_range(0, 7) == 0);
            right = ($urandom_range(0, 7) == 0);
            haz   = ($urandom_range(0, 15) == 0);
            brake = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 249) == 0) begin
                #2 rst_b = 1'b0;
                nxt();
                rst_b = 1'b1;
            end
            nxt();
        end
        settle();

        // 5-lamp, TICK_DIV=1 instance with left held
        left = 1'b1; nxt();
        for (int i = 0; i < 14; i++) begin
            lit("n5_l", 16'(lb), 16'(seq_b[i % 7]));
            lit("n5_busy", 16'(busy_b), ((i % 7) != 6) ? 16'd1 : 16'd0);
            nxt();
        end
        settle();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
